// File: rtl/grey_decode.sv
// grey_decode: converts the upstream 6-bit Gray count to binary, turns each
// single-code step into an up/down pulse and tracks a signed position.
// Any jump larger than one code latches a sticky fault until i_clear.
//
// Build option GREY_DECODE_SYNC_EN:
//   defined   -> i_grey_code is asynchronous; two-flop synchronizer (N_SYNC=2)
//   undefined -> same-clock source; one plain input register (N_SYNC=1)
// The pipeline depth follows N_SYNC; behaviour is otherwise identical.
//
// Handshake: there is none. The decoder samples i_grey_code on every clock.
// o_up/o_dn are single-cycle pulses that are qualified only by o_valid.
// The upstream counter must not step more often than once every N_SYNC+1 clocks.
module grey_decode #(
  parameter int WIDTH = 6,
  parameter int POS_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_grey_code,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_binary,
  output logic             o_up,
  output logic             o_dn,
  output logic [POS_W-1:0] o_pos,
  output logic             o_valid,
  output logic             o_fault,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP_UP = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_DN = '1;

  state_t           state;
  logic [WIDTH-1:0] sync_code;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] delta;
  logic [1:0]       fill_cnt;
  logic             filled;

`ifdef GREY_DECODE_SYNC_EN
  localparam int N_SYNC = 2;

  // First stage may go metastable; only the second stage feeds logic.
  (* async_reg = "true" *) logic [WIDTH-1:0] sync_meta;

  // Two-flop synchronizer for a Gray bus coming from another clock region.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_meta <= '0;
      sync_code <= '0;
    end else begin
      sync_meta <= i_grey_code;
      sync_code <= sync_meta;
    end
  end
`else
  localparam int N_SYNC = 1;

  // Single input register for a same-clock source.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_code <= '0;
    end else begin
      sync_code <= i_grey_code;
    end
  end
`endif

  localparam logic [1:0] FILL_DONE = 2'(N_SYNC + 1);

  // Gray to binary conversion: each bit is the XOR of all Gray bits at and above it.
  always_comb begin
    bin_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_next[i] = ^(sync_code >> i);
    end
  end

  // Register the converted code so the compare stage sees a clean value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bin_q <= '0;
    end else begin
      bin_q <= bin_next;
    end
  end

  // Count edges since reset until the reset zeros are flushed out of the pipeline.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fill_cnt <= '0;
    end else if (!filled) begin
      fill_cnt <= fill_cnt + 2'd1;
    end
  end

  assign filled = (fill_cnt == FILL_DONE);

  // Modular distance from the last accepted code; wrap 63->0 gives +1.
  assign delta = bin_q - o_binary;

  // Tracking FSM with all outputs registered; the pulses default low each cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_INIT;
      o_binary  <= '0;
      o_up      <= 1'b0;
      o_dn      <= 1'b0;
      o_pos     <= '0;
      o_valid   <= 1'b0;
      o_fault   <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      o_up <= 1'b0;
      o_dn <= 1'b0;
      case (state)
        ST_INIT: begin
          if (i_clear) begin
            o_valid <= 1'b0;
          end else if (filled) begin
            // Take the first good sample as the baseline; it is not a step.
            o_binary <= bin_q;
            o_valid  <= 1'b1;
            state    <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (i_clear) begin
            // A clear wins over anything detected this cycle.
            o_valid <= 1'b0;
            state   <= ST_INIT;
          end else if (delta == STEP_UP) begin
            o_binary <= bin_q;
            o_up     <= 1'b1;
            o_pos    <= o_pos + POS_W'(1);
          end else if (delta == STEP_DN) begin
            o_binary <= bin_q;
            o_dn     <= 1'b1;
            o_pos    <= o_pos - POS_W'(1);
          end else if (delta != '0) begin
            // Jump of more than one code: position and binary hold.
            o_valid <= 1'b0;
            o_fault <= 1'b1;
            state   <= ST_FAULT;
            if (o_err_cnt != '1) begin
              o_err_cnt <= o_err_cnt + ERR_W'(1);
            end
          end
        end
        ST_FAULT: begin
          if (i_clear) begin
            o_fault <= 1'b0;
            state   <= ST_INIT;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_grey_decode.sv
// Bench for grey_decode: reset/fill behaviour, table-driven steps, full walk
// with wrap, fault and clear, clear racing a fault, mid-run reset and error
// counter saturation. Latency tracks GREY_DECODE_SYNC_EN.
module tb_grey_decode;

  localparam int WIDTH = 6;
  localparam int POS_W = 16;
  localparam int ERR_W = 8;
`ifdef GREY_DECODE_SYNC_EN
  localparam int N_SYNC = 2;
`else
  localparam int N_SYNC = 1;
`endif
  localparam int LAT   = N_SYNC + 2;
  localparam int EXP_W = 2 + POS_W + WIDTH + 2 + ERR_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic [WIDTH-1:0] grey;
  logic [WIDTH-1:0] o_binary;
  logic             o_up;
  logic             o_dn;
  logic [POS_W-1:0] o_pos;
  logic             o_valid;
  logic             o_fault;
  logic [ERR_W-1:0] o_err_cnt;
  logic [1:0]       o_state;

  int n_total = 0;
  int n_bad   = 0;

  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] grey;
    logic             up;
    logic             dn;
    logic [POS_W-1:0] pos;
    logic [WIDTH-1:0] bin;
  } vec_t;

  vec_t vec[8];

  grey_decode dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_grey_code (grey),
    .i_clear     (clear),
    .o_binary    (o_binary),
    .o_up        (o_up),
    .o_dn        (o_dn),
    .o_pos       (o_pos),
    .o_valid     (o_valid),
    .o_fault     (o_fault),
    .o_err_cnt   (o_err_cnt),
    .o_state     (o_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [WIDTH-1:0] gray(input int b);
    logic [WIDTH-1:0] v;
    v = WIDTH'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [EXP_W-1:0] mk(input logic up, input logic dn,
                                          input logic [POS_W-1:0] pos,
                                          input logic [WIDTH-1:0] bin,
                                          input logic valid, input logic fault,
                                          input logic [ERR_W-1:0] err);
    return {up, dn, pos, bin, valid, fault, err};
  endfunction

  function automatic logic [EXP_W-1:0] act_vec();
    return {o_up, o_dn, o_pos, o_binary, o_valid, o_fault, o_err_cnt};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one code, then check: no pulse one cycle early, full outputs at
  // the expected latency, and the pulse gone one cycle later.
  task automatic apply(input string name, input logic [WIDTH-1:0] g,
                       input logic [EXP_W-1:0] e);
    logic [EXP_W-1:0] want;
    @(negedge clk);
    grey = g;
    exp_q.push_back(e);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check({name, " early"}, 64'({o_up, o_dn}), 64'(0));
    @(posedge clk);
    @(negedge clk);
    want = exp_q.pop_front();
    check(name, 64'(act_vec()), 64'(want));
    @(posedge clk);
    @(negedge clk);
    check({name, " pulse end"}, 64'({o_up, o_dn}), 64'(0));
  endtask

  // Pulse i_clear from FAULT/TRACK and check the re-baseline one cycle later.
  task automatic do_clear(input string name, input logic [WIDTH-1:0] bin_after,
                          input logic [POS_W-1:0] pos, input logic [ERR_W-1:0] err);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    check({name, " cleared"}, 64'({o_state, o_valid, o_fault, o_up, o_dn}), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check({name, " rebase"}, 64'(act_vec()), 64'(mk(0, 0, pos, bin_after, 1, 0, err)));
  endtask

  // Release reset and check the fill window and the first baseline sample.
  task automatic release_reset(input logic [WIDTH-1:0] bin_after);
    reset = 1'b0;
    repeat (N_SYNC + 1) @(posedge clk);
    @(negedge clk);
    check("fill not valid", 64'({o_valid, o_state}), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check("init baseline", 64'(act_vec()), 64'(mk(0, 0, 0, bin_after, 1, 0, 0)));
  endtask

  // ---------------- main test ----------------
  initial begin
    int pos;
    int c;
    int c2;
    logic [ERR_W-1:0] exp_err;

    vec[0] = '{6'h00, 1'b0, 1'b1, 16'h0000, 6'd0};
    vec[1] = '{6'h20, 1'b0, 1'b1, 16'hFFFF, 6'd63};
    vec[2] = '{6'h00, 1'b1, 1'b0, 16'h0000, 6'd0};
    vec[3] = '{6'h01, 1'b1, 1'b0, 16'h0001, 6'd1};
    vec[4] = '{6'h03, 1'b1, 1'b0, 16'h0002, 6'd2};
    vec[5] = '{6'h01, 1'b0, 1'b1, 16'h0001, 6'd1};
    vec[6] = '{6'h01, 1'b0, 1'b0, 16'h0001, 6'd1};
    vec[7] = '{6'h00, 1'b0, 1'b1, 16'h0000, 6'd0};

    reset = 1'b1;
    clear = 1'b0;
    grey  = 6'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset state", 64'({act_vec(), o_state}), 64'(0));
    release_reset(6'd0);

    // single up step, latency checked inside apply
    apply("first up", 6'h01, mk(1, 0, 16'd1, 6'd1, 1, 0, 0));

    // table: down, wrap both ways, hold
    for (int i = 0; i < 8; i++) begin
      apply($sformatf("vec%0d", i), vec[i].grey,
            mk(vec[i].up, vec[i].dn, vec[i].pos, vec[i].bin, 1, 0, 0));
    end

    // full walk 1..63 then 63->0 as +1
    pos = 0;
    for (int b = 1; b <= 64; b++) begin
      pos++;
      apply($sformatf("walk%0d", b), gray(b % 64),
            mk(1, 0, POS_W'(pos), WIDTH'(b % 64), 1, 0, 0));
    end
    check("walk pos", 64'(o_pos), 64'(64));

    // up to binary 5, then jump to 9 -> fault
    for (int b = 1; b <= 5; b++) begin
      pos++;
      apply($sformatf("pre fault%0d", b), gray(b), mk(1, 0, POS_W'(pos), WIDTH'(b), 1, 0, 0));
    end
    apply("jump fault", gray(9), mk(0, 0, POS_W'(pos), 6'd5, 0, 1, 8'd1));
    apply("fault hold", gray(10), mk(0, 0, POS_W'(pos), 6'd5, 0, 1, 8'd1));
    do_clear("fault clear", 6'd10, POS_W'(pos), 8'd1);
    pos++;
    apply("after clear up", gray(11), mk(1, 0, POS_W'(pos), 6'd11, 1, 0, 8'd1));

    // clear lands on the same edge the bad jump would be detected
    @(negedge clk);
    grey = gray(20);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    check("clear beats fault", 64'({o_fault, o_valid, o_err_cnt}), 64'({1'b0, 1'b0, 8'd1}));
    @(posedge clk);
    @(negedge clk);
    check("clear race rebase", 64'(act_vec()), 64'(mk(0, 0, POS_W'(pos), 6'd20, 1, 0, 8'd1)));

    // mid-run reset discards everything
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid reset", 64'({act_vec(), o_state}), 64'(0));
    release_reset(6'd20);
    apply("post reset up", gray(21), mk(1, 0, 16'd1, 6'd21, 1, 0, 0));

    // error counter saturation
    c = 21;
    exp_err = '0;
    for (int i = 0; i < 256; i++) begin
      c2 = (c + 4) % 64;
      exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
      apply($sformatf("sat fault%0d", i), gray(c2), mk(0, 0, 16'd1, WIDTH'(c), 0, 1, exp_err));
      do_clear($sformatf("sat clear%0d", i), WIDTH'(c2), 16'd1, exp_err);
      c = c2;
    end
    check("err saturated", 64'(o_err_cnt), 64'(8'hFF));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
